// File: rtl/j1_reset_pkg.sv
// Shared types and default parameters for the PLL-lock driven reset sequencer.
package j1_reset_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2,
    GLITCH    = 2'd3
  } seqState_e;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_STABLE_CYCLES  = 4096;
  localparam int DEF_LOSS_FILTER    = 4;
  localparam int DEF_LOSS_CNT_WIDTH = 8;

endpackage

// File: rtl/lock_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous flag; async-reset to 0.
module lock_synchronizer #(
  parameter int STAGES = j1_reset_pkg::DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic asyncFlag,
  output logic lockSync
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) chain <= '0;
    else       chain <= {chain[STAGES-2:0], asyncFlag};
  end

  assign lockSync = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Turns the raw PLL lock flag into a qualified core reset, filtering short
// lock dropouts and counting real lock losses.
module pll_reset_sequencer
  import j1_reset_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int LOSS_FILTER    = DEF_LOSS_FILTER,
  parameter int LOSS_CNT_WIDTH = DEF_LOSS_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      isLocked,
  output logic                      coreReset,
  output logic                      isReady,
  output logic [LOSS_CNT_WIDTH-1:0] lockLossCount
);

  localparam int STABLE_W = $clog2(STABLE_CYCLES + 1);
  localparam int LOSS_W   = $clog2(LOSS_FILTER + 1);
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES);
  localparam logic [LOSS_W-1:0]   LOSS_LAST   = LOSS_W'(LOSS_FILTER);

  function automatic logic [LOSS_CNT_WIDTH-1:0] satInc(input logic [LOSS_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + LOSS_CNT_WIDTH'(1);
  endfunction

  logic                lockSync;
  seqState_e           state, stateNext;
  logic [STABLE_W-1:0] stableCnt, stableCntNext;
  logic [LOSS_W-1:0]   lossCnt, lossCntNext;
  logic                lossEvent;
  logic                coreResetNext, isReadyNext;

  lock_synchronizer #(.STAGES(SYNC_STAGES)) uSync (
    .clk      (clk),
    .reset    (reset),
    .asyncFlag(isLocked),
    .lockSync (lockSync)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= WAIT_LOCK;
      stableCnt     <= '0;
      lossCnt       <= '0;
      coreReset     <= 1'b1;
      isReady       <= 1'b0;
      lockLossCount <= '0;
    end else begin
      state     <= stateNext;
      stableCnt <= stableCntNext;
      lossCnt   <= lossCntNext;
      coreReset <= coreResetNext;
      isReady   <= isReadyNext;
      if (lossEvent) lockLossCount <= satInc(lockLossCount);
    end
  end

  always_comb begin
    stateNext     = state;
    stableCntNext = stableCnt;
    lossCntNext   = lossCnt;
    lossEvent     = 1'b0;
    case (state)
      WAIT_LOCK: begin
        lossCntNext = '0;
        if (lockSync) begin
          stateNext     = STABILIZE;
          stableCntNext = STABLE_W'(1);
        end
      end
      STABILIZE: begin
        if (!lockSync)                   stateNext     = WAIT_LOCK;
        else if (stableCnt == STABLE_LAST) stateNext   = RUN;
        else                             stableCntNext = stableCnt + STABLE_W'(1);
      end
      RUN: begin
        if (!lockSync) begin
          // A single-cycle filter means there is no glitch window at all.
          if (LOSS_FILTER == 1) begin
            stateNext = WAIT_LOCK;
            lossEvent = 1'b1;
          end else begin
            stateNext   = GLITCH;
            lossCntNext = LOSS_W'(1);
          end
        end
      end
      GLITCH: begin
        if (lockSync) begin
          stateNext   = RUN;
          lossCntNext = '0;
        end else if (lossCnt + LOSS_W'(1) == LOSS_LAST) begin
          stateNext   = WAIT_LOCK;
          lossEvent   = 1'b1;
          lossCntNext = '0;
        end else begin
          lossCntNext = lossCnt + LOSS_W'(1);
        end
      end
      default: stateNext = WAIT_LOCK;
    endcase
    if (stateNext == WAIT_LOCK) stableCntNext = '0;
  end

  // Outputs are decoded from the next state so they move with the state register.
  always_comb begin
    coreResetNext = 1'b1;
    isReadyNext   = 1'b0;
    case (stateNext)
      RUN: begin
        coreResetNext = 1'b0;
        isReadyNext   = 1'b1;
      end
      GLITCH:  coreResetNext = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus a randomized run,
// all checked against a run-length model of the lock qualification rules.
module tb_pll_reset_sequencer;

  localparam int SYNC   = 2;
  localparam int STABLE = 16;
  localparam int LOSS   = 4;
  localparam int CW     = 8;
  localparam int REL    = SYNC + STABLE + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          isLocked;
  logic          coreReset;
  logic          isReady;
  logic [CW-1:0] lockLossCount;

  int errors = 0;
  int checks = 0;

  pll_reset_sequencer #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE),
    .LOSS_FILTER   (LOSS),
    .LOSS_CNT_WIDTH(CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .isLocked     (isLocked),
    .coreReset    (coreReset),
    .isReady      (isReady),
    .lockLossCount(lockLossCount)
  );

  always #5 clk = ~clk;

  // Reference: lock history delayed by the sync depth, then run-length counting
  // of consecutive high samples (to qualify) and low samples (to declare a loss).
  logic [SYNC-1:0] mHist;
  logic            mSeen;
  int              mHigh, mLow, mLoss;
  bit              mRun;
  logic            expCore, expReady;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mHist = '0; mHigh = 0; mLow = 0; mLoss = 0; mRun = 0;
    end else begin
      mSeen = mHist[SYNC-1];
      mHist = {mHist[SYNC-2:0], isLocked};
      if (!mRun) begin
        mHigh = mSeen ? mHigh + 1 : 0;
        if (mHigh == STABLE + 1) begin mRun = 1; mLow = 0; end
      end else if (!mSeen) begin
        mLow = mLow + 1;
        if (mLow == LOSS) begin
          mRun = 0; mHigh = 0; mLow = 0;
          if (mLoss < (1 << CW) - 1) mLoss = mLoss + 1;
        end
      end else begin
        mLow = 0;
      end
    end
    expCore  = !mRun;
    expReady = mRun && (mLow == 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; isLocked = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if (coreReset !== 1'b1 || isReady !== 1'b0 || lockLossCount !== '0) begin
        errors++;
        $display("FAIL reset_hold: core=%b ready=%b cnt=%0d, want 1 0 0", coreReset, isReady, lockLossCount);
      end
    end
    reset = 1'b0;
    for (int e = 1; e <= REL; e++) begin
      tick();
      checks++;
      if (coreReset !== (e < REL) || isReady !== (e >= REL)) begin
        errors++;
        $display("FAIL release_edge%0d: core=%b ready=%b, want %b %b", e, coreReset, isReady, e < REL, e >= REL);
      end
      checks++;
      if (coreReset !== expCore || isReady !== expReady) begin
        errors++;
        $display("FAIL release_model%0d: core=%b ready=%b, want %b %b", e, coreReset, isReady, expCore, expReady);
      end
    end
  endtask

  task automatic test_short_glitch();
    int readyLow = 0;
    for (int c = 0; c < 13; c++) begin
      isLocked = (c >= 3);
      tick();
      if (isReady === 1'b0) readyLow++;
      checks++;
      if (coreReset !== 1'b0 || lockLossCount !== '0) begin
        errors++;
        $display("FAIL glitch_cyc%0d: core=%b cnt=%0d, want 0 0", c, coreReset, lockLossCount);
      end
    end
    checks++;
    if (readyLow != 3) begin
      errors++;
      $display("FAIL glitch_ready_low: got %0d cycles, want 3", readyLow);
    end
  endtask

  task automatic test_loss_held();
    isLocked = 1'b0;
    for (int k = 1; k <= SYNC + LOSS + 4; k++) begin
      tick();
      checks++;
      if (coreReset !== (k >= SYNC + LOSS)) begin
        errors++;
        $display("FAIL loss_edge%0d: core=%b, want %b", k, coreReset, k >= SYNC + LOSS);
      end
    end
    checks++;
    if (lockLossCount !== CW'(1) || isReady !== 1'b0) begin
      errors++;
      $display("FAIL loss_count: cnt=%0d ready=%b, want 1 0", lockLossCount, isReady);
    end
  endtask

  task automatic test_stabilize_restart();
    isLocked = 1'b1;
    repeat (10) tick();
    isLocked = 1'b0;
    tick();
    checks++;
    if (coreReset !== 1'b1) begin
      errors++;
      $display("FAIL stab_pre: core=%b, want 1", coreReset);
    end
    isLocked = 1'b1;
    for (int e = 1; e <= REL; e++) begin
      tick();
      checks++;
      if (coreReset !== (e < REL)) begin
        errors++;
        $display("FAIL restart_edge%0d: core=%b, want %b", e, coreReset, e < REL);
      end
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (coreReset !== 1'b1 || isReady !== 1'b0 || lockLossCount !== '0) begin
      errors++;
      $display("FAIL async_assert: core=%b ready=%b cnt=%0d, want 1 0 0", coreReset, isReady, lockLossCount);
    end
    tick();
    reset = 1'b0;
    for (int e = 1; e <= REL; e++) begin
      tick();
      checks++;
      if (coreReset !== (e < REL) || isReady !== (e >= REL)) begin
        errors++;
        $display("FAIL rerelease_edge%0d: core=%b ready=%b, want %b %b", e, coreReset, isReady, e < REL, e >= REL);
      end
    end
  endtask

  task automatic test_saturate();
    int want;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 260; i++) begin
      int n = 0;
      isLocked = 1'b1;
      while (isReady !== 1'b1 && n < 40) begin tick(); n++; end
      if (isReady !== 1'b1) begin
        errors++; checks++;
        $display("FAIL sat_wait_ready: loss %0d, ready=%b after %0d cycles, want 1", i, isReady, n);
        break;
      end
      n = 0;
      isLocked = 1'b0;
      while (coreReset !== 1'b1 && n < 12) begin tick(); n++; end
      want = (i > 255) ? 255 : i;
      checks++;
      if (lockLossCount !== CW'(want) || coreReset !== 1'b1) begin
        errors++;
        $display("FAIL sat_loss%0d: cnt=%0d core=%b, want %0d 1", i, lockLossCount, coreReset, want);
      end
    end
    checks++;
    if (lockLossCount !== 8'hFF || mLoss != 255) begin
      errors++;
      $display("FAIL sat_final: cnt=%0d model=%0d, want 255", lockLossCount, mLoss);
    end
  endtask

  task automatic test_random();
    bit lvl = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int seg = 0; seg < 80; seg++) begin
      int len = lvl ? $urandom_range(5, 40) : $urandom_range(1, 2 * LOSS);
      isLocked = lvl;
      for (int c = 0; c < len; c++) begin
        tick();
        checks++;
        if (coreReset !== expCore || isReady !== expReady || lockLossCount !== CW'(mLoss)) begin
          errors++;
          $display("FAIL rand_seg%0d: core=%b ready=%b cnt=%0d, want %b %b %0d",
                   seg, coreReset, isReady, lockLossCount, expCore, expReady, mLoss);
        end
      end
      lvl = !lvl;
    end
  endtask

  initial begin
    test_reset();
    test_short_glitch();
    test_loss_held();
    test_stabilize_restart();
    test_async_reset();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
